intra_net_tile_sched: RTL and testbench
=======================================

INTRA_NET_TILE_SCHED -- requirements
Module: intra_net_tile_sched

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, buffer address width.
REQ-002 SHALL have parameter COL_DIM, default 16, array column count; RW = $clog2(COL_DIM)+1.
REQ-003 SHALL have parameter TILE_WIDTH, default 8, tile-count width.
REQ-004 SHALL have port clk  input  1  clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-008 SHALL have ports cmd_o_base, cmd_a_base  input  ADDR_WIDTH  first-tile output and activation base addresses.
REQ-009 SHALL have ports cmd_o_stride, cmd_a_stride  input  ADDR_WIDTH  per-tile base increments.
REQ-010 SHALL have port cmd_rows  input  RW  rows per tile (generator A operand).
REQ-011 SHALL have port cmd_num_tiles  input  TILE_WIDTH  tile count.
REQ-012 SHALL have port abort  input  1  synchronous abort of the current command.
REQ-013 SHALL have port gen_start  output  1  start level to the address generator.
REQ-014 SHALL have ports gen_o_base, gen_a_base  output  ADDR_WIDTH  current tile bases.
REQ-015 SHALL have port gen_rows  output  RW  latched cmd_rows.
REQ-016 SHALL have port tile_idx  output  TILE_WIDTH  index of current tile.
REQ-017 SHALL have ports busy  output  1  (state != IDLE); done  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, RUN, GAP, DONE.
REQ-019 SHALL drive cmd_ready high only in IDLE; handshake = cmd_valid & cmd_ready on a clock edge.
REQ-020 SHALL on handshake latch all cmd_* fields, load gen_o_base/gen_a_base with the bases, tile_idx=0, cycle counter=0.
REQ-021 SHALL on handshake with cmd_rows==0 or cmd_num_tiles==0 go IDLE->DONE, never asserting gen_start.
REQ-022 SHALL otherwise go IDLE->RUN; gen_start high exactly in RUN (registered output, no glitch).
REQ-023 SHALL stay in RUN exactly 2*rows cycles (counter 0..2*rows-1), then enter GAP.
REQ-024 SHALL stay in GAP exactly 2 cycles with gen_start low, so the generator counter returns to zero between tiles.
REQ-025 SHALL at GAP exit, if tile_idx==num_tiles-1, enter DONE; else increment tile_idx, add strides to both bases, re-enter RUN.
REQ-026 SHALL compute base updates modulo 2^ADDR_WIDTH (wrap, no saturation); counter width SHALL hold 2*(2^RW-1) without overflow.
REQ-027 SHALL hold gen_o_base, gen_a_base, gen_rows constant throughout each RUN and GAP.
REQ-028 SHALL in DONE pulse done for one cycle, then return to IDLE next cycle.
REQ-029 SHALL on abort in RUN or GAP drop gen_start the next edge and go to DONE; abort in IDLE/DONE SHALL be ignored.
REQ-030 SHALL give abort priority over normal RUN/GAP transitions in the same cycle.
REQ-031 SHALL ignore cmd_valid outside IDLE; a new command is first accepted the cycle after DONE.

Reset
REQ-032 SHALL on reset asynchronously enter IDLE: gen_start=0, done=0, busy=0, cmd_ready=1 after release, tile_idx=0, bases=0, gen_rows=0, counters=0.
REQ-033 SHALL on reset mid-command discard the command with no done pulse.

Verification
REQ-034 Single tile: rows=4, tiles=1, bases 0x010/0x200 -> gen_start high 8 cycles, 2 low GAP, done one cycle later, gen bases unchanged.
REQ-035 Multi-tile: rows=3, tiles=3, o_stride=0x10, a_stride=0x20 from 0x000/0x100 -> three 6-cycle start bursts, bases 0x000/0x100, 0x010/0x120, 0x020/0x140, 2-cycle gaps, tile_idx 0,1,2, one done.
REQ-036 Wrap: o_base=0x3F8, o_stride=0x10, tiles=2 -> second tile gen_o_base=0x008.
REQ-037 Degenerate: rows=0 or tiles=0 -> no gen_start, done pulse the cycle after handshake, cmd_ready back next cycle.
REQ-038 Abort in tile 1 RUN of 3 -> gen_start low next edge, done pulses, no tile 2; cmd_valid held during run not accepted until IDLE.
REQ-039 Reset asserted during RUN -> gen_start, busy low immediately; no done; fresh command accepted after release.

Source files
------------

// File: rtl/intra_net_tile_sched.sv
// Tile scheduler for the intra-network compute array.
// Accepts one command describing a run of tiles. For each tile it holds
// gen_start high for 2*rows cycles and then low for two gap cycles so the
// downstream address generator returns to zero. The output and activation
// base addresses advance by their strides between tiles.
module intra_net_tile_sched #(
  parameter int ADDR_WIDTH = 10,
  parameter int COL_DIM    = 16,
  parameter int TILE_WIDTH = 8,
  localparam int RW        = $clog2(COL_DIM) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_o_base,
  input  logic [ADDR_WIDTH-1:0] cmd_a_base,
  input  logic [ADDR_WIDTH-1:0] cmd_o_stride,
  input  logic [ADDR_WIDTH-1:0] cmd_a_stride,
  input  logic [RW-1:0]         cmd_rows,
  input  logic [TILE_WIDTH-1:0] cmd_num_tiles,
  input  logic                  abort,
  output logic                  gen_start,
  output logic [ADDR_WIDTH-1:0] gen_o_base,
  output logic [ADDR_WIDTH-1:0] gen_a_base,
  output logic [RW-1:0]         gen_rows,
  output logic [TILE_WIDTH-1:0] tile_idx,
  output logic                  busy,
  output logic                  done
);

  // One extra bit over RW so the run counter can reach 2*(2^RW-1).
  localparam int CW = RW + 1;

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  state_t                  state_q, state_nx;
  logic [CW-1:0]           cnt_q;
  logic [ADDR_WIDTH-1:0]   o_stride_q, a_stride_q;
  logic [TILE_WIDTH-1:0]   num_tiles_q;
  logic                    gen_start_q;
  logic [CW-1:0]           run_last;
  logic                    last_tile;
  logic                    degenerate;

  // Base addresses wrap around the buffer; never saturate.
  function automatic logic [ADDR_WIDTH-1:0] add_wrap(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [ADDR_WIDTH-1:0] b
  );
    return a + b;
  endfunction

  assign run_last   = {gen_rows, 1'b0} - CW'(1);
  assign last_tile  = (tile_idx == num_tiles_q - TILE_WIDTH'(1));
  assign degenerate = (cmd_rows == '0) || (cmd_num_tiles == '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nx;
  end

  // Next-state logic; abort overrides the normal RUN/GAP progression
  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE: if (cmd_valid) state_nx = degenerate ? DONE : RUN;
      RUN: begin
        if (abort)                 state_nx = DONE;
        else if (cnt_q == run_last) state_nx = GAP;
      end
      GAP: begin
        if (abort)                 state_nx = DONE;
        else if (cnt_q == CW'(1))  state_nx = last_tile ? DONE : RUN;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    gen_start = gen_start_q;
  end

  // Command latch, per-tile base stepping and phase counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gen_start_q <= 1'b0;
      gen_o_base  <= '0;
      gen_a_base  <= '0;
      o_stride_q  <= '0;
      a_stride_q  <= '0;
      gen_rows    <= '0;
      num_tiles_q <= '0;
      tile_idx    <= '0;
      cnt_q       <= '0;
    end else begin
      // gen_start is a flop so the generator never sees a decode glitch
      gen_start_q <= (state_nx == RUN);
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            gen_o_base  <= cmd_o_base;
            gen_a_base  <= cmd_a_base;
            o_stride_q  <= cmd_o_stride;
            a_stride_q  <= cmd_a_stride;
            gen_rows    <= cmd_rows;
            num_tiles_q <= cmd_num_tiles;
            tile_idx    <= '0;
            cnt_q       <= '0;
          end
        end
        RUN: begin
          cnt_q <= (state_nx == RUN) ? cnt_q + CW'(1) : '0;
        end
        GAP: begin
          cnt_q <= (state_nx == GAP) ? cnt_q + CW'(1) : '0;
          if (state_nx == RUN) begin
            tile_idx   <= tile_idx + TILE_WIDTH'(1);
            gen_o_base <= add_wrap(gen_o_base, o_stride_q);
            gen_a_base <= add_wrap(gen_a_base, a_stride_q);
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_intra_net_tile_sched.sv
// Testbench for intra_net_tile_sched: a table of directed commands with
// hand-derived totals, hand-written reset sequences, and random commands,
// all checked cycle by cycle against a schedule-expansion model.
module tb_intra_net_tile_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_o_base, cmd_a_base, cmd_o_stride, cmd_a_stride;
  logic [4:0] cmd_rows;
  logic [7:0] cmd_num_tiles;
  logic       abort;
  logic       gen_start;
  logic [9:0] gen_o_base, gen_a_base;
  logic [4:0] gen_rows;
  logic [7:0] tile_idx;
  logic       busy, done;

  int vectors = 0;
  int errors  = 0;

  intra_net_tile_sched dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_o_base(cmd_o_base), .cmd_a_base(cmd_a_base),
    .cmd_o_stride(cmd_o_stride), .cmd_a_stride(cmd_a_stride),
    .cmd_rows(cmd_rows), .cmd_num_tiles(cmd_num_tiles), .abort(abort),
    .gen_start(gen_start), .gen_o_base(gen_o_base), .gen_a_base(gen_a_base),
    .gen_rows(gen_rows), .tile_idx(tile_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         start;
    logic [9:0] ob, ab;
    logic [7:0] ti;
    bit         dn, bsy, rdy;
    logic [4:0] rows;
  } exp_t;

  typedef struct {
    string      name;
    logic [9:0] ob, ab, os, as;
    logic [4:0] rows;
    logic [7:0] tiles;
    int         abort_at;
    bit         hold;
    int         exp_start, exp_busy;
    logic [9:0] exp_lo, exp_la;
  } vec_t;

  exp_t q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input exp_t e);
    vectors++;
    if (gen_start !== e.start || gen_o_base !== e.ob || gen_a_base !== e.ab ||
        tile_idx !== e.ti || done !== e.dn || busy !== e.bsy ||
        cmd_ready !== e.rdy || gen_rows !== e.rows) begin
      errors++;
      $display("FAIL %s t=%0t got st=%0b o=%h a=%h idx=%0d dn=%0b bsy=%0b rdy=%0b rows=%0d exp st=%0b o=%h a=%h idx=%0d dn=%0b bsy=%0b rdy=%0b rows=%0d",
               nm, $time, gen_start, gen_o_base, gen_a_base, tile_idx, done, busy,
               cmd_ready, gen_rows, e.start, e.ob, e.ab, e.ti, e.dn, e.bsy, e.rdy, e.rows);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    vectors++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, want);
    end
  endtask

  // Expand a command into its expected cycle-by-cycle schedule.
  function automatic void build(input logic [9:0] ob, ab, os, as,
                                input logic [4:0] rows, input logic [7:0] tiles,
                                input int abort_at);
    exp_t e, last;
    q.delete();
    e.rdy = 1'b0; e.bsy = 1'b1; e.rows = rows; e.dn = 1'b0;
    if (rows == 0 || tiles == 0) begin
      e.start = 1'b0; e.ob = ob; e.ab = ab; e.ti = 8'd0; e.dn = 1'b1;
      q.push_back(e);
      return;
    end
    for (int t = 0; t < int'(tiles); t++) begin
      e.ob = 10'(int'(ob) + t * int'(os));
      e.ab = 10'(int'(ab) + t * int'(as));
      e.ti = 8'(t);
      e.start = 1'b1;
      for (int c = 0; c < 2 * int'(rows); c++) q.push_back(e);
      e.start = 1'b0;
      repeat (2) q.push_back(e);
    end
    if (abort_at >= 0 && abort_at < q.size()) q = q[0:abort_at];
    last = q[q.size() - 1];
    last.start = 1'b0; last.dn = 1'b1;
    q.push_back(last);
  endfunction

  task automatic run_cmd(input string nm, input logic [9:0] ob, ab, os, as,
                         input logic [4:0] rows, input logic [7:0] tiles,
                         input int abort_at, input bit hold,
                         output int n_start, output int n_busy,
                         output logic [9:0] lo, output logic [9:0] la);
    exp_t e;
    int   ab_eff;
    n_start = 0; n_busy = 0; lo = '0; la = '0;
    for (int i = 0; i < 20 && !cmd_ready; i++) step();
    vectors++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL %s ready_wait got cmd_ready=0 expected 1", nm);
      return;
    end
    build(ob, ab, os, as, rows, tiles, abort_at);
    ab_eff = (abort_at >= 0 && abort_at < q.size() - 1) ? abort_at : -1;
    cmd_valid = 1'b1; cmd_o_base = ob; cmd_a_base = ab;
    cmd_o_stride = os; cmd_a_stride = as; cmd_rows = rows; cmd_num_tiles = tiles;
    step();
    if (hold) begin
      cmd_o_base = 10'h3FF; cmd_a_base = 10'h2AA; cmd_rows = 5'd1; cmd_num_tiles = 8'd9;
    end else cmd_valid = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      chk(nm, q[i]);
      if (gen_start) n_start++;
      if (busy) n_busy++;
      lo = gen_o_base; la = gen_a_base;
      abort = (i == ab_eff);
      if (i == q.size() - 1) cmd_valid = 1'b0;
      step();
    end
    abort = 1'b0;
    e = q[q.size() - 1];
    e.dn = 1'b0; e.bsy = 1'b0; e.rdy = 1'b1;
    chk({nm, "_idle"}, e);
  endtask

  vec_t tbl[8];

  initial begin
    exp_t z;
    int ns, nb;
    logic [9:0] lo, la;

    tbl[0] = '{"single",   10'h010, 10'h200, 10'h000, 10'h000, 5'd4,  8'd1, -1, 1'b0,  8, 11, 10'h010, 10'h200};
    tbl[1] = '{"multi",    10'h000, 10'h100, 10'h010, 10'h020, 5'd3,  8'd3, -1, 1'b0, 18, 25, 10'h020, 10'h140};
    tbl[2] = '{"wrap",     10'h3F8, 10'h000, 10'h010, 10'h000, 5'd2,  8'd2, -1, 1'b0,  8, 13, 10'h008, 10'h000};
    tbl[3] = '{"rows0",    10'h0AA, 10'h155, 10'h001, 10'h001, 5'd0,  8'd5, -1, 1'b0,  0,  1, 10'h0AA, 10'h155};
    tbl[4] = '{"tiles0",   10'h123, 10'h321, 10'h001, 10'h001, 5'd5,  8'd0, -1, 1'b0,  0,  1, 10'h123, 10'h321};
    tbl[5] = '{"abort_run",10'h000, 10'h100, 10'h010, 10'h020, 5'd3,  8'd3, 10, 1'b1,  9, 12, 10'h010, 10'h120};
    tbl[6] = '{"maxrows",  10'h000, 10'h000, 10'h000, 10'h000, 5'd31, 8'd1, -1, 1'b0, 62, 65, 10'h000, 10'h000};
    tbl[7] = '{"abort_gap",10'h050, 10'h060, 10'h001, 10'h001, 5'd2,  8'd2,  4, 1'b0,  4,  6, 10'h050, 10'h060};

    reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_o_base = '0; cmd_a_base = '0; cmd_o_stride = '0; cmd_a_stride = '0;
    cmd_rows = '0; cmd_num_tiles = '0;

    z.start = 1'b0; z.ob = '0; z.ab = '0; z.ti = '0; z.dn = 1'b0;
    z.bsy = 1'b0; z.rdy = 1'b1; z.rows = '0;
    repeat (3) step();
    chk("reset_hold", z);
    reset = 1'b0;
    step();
    chk("reset_release", z);

    for (int v = 0; v < 8; v++) begin
      run_cmd(tbl[v].name, tbl[v].ob, tbl[v].ab, tbl[v].os, tbl[v].as, tbl[v].rows,
              tbl[v].tiles, tbl[v].abort_at, tbl[v].hold, ns, nb, lo, la);
      chk_int({tbl[v].name, "_start_cycles"}, ns, tbl[v].exp_start);
      chk_int({tbl[v].name, "_busy_cycles"}, nb, tbl[v].exp_busy);
      chk_int({tbl[v].name, "_last_o"}, int'(lo), int'(tbl[v].exp_lo));
      chk_int({tbl[v].name, "_last_a"}, int'(la), int'(tbl[v].exp_la));
    end

    // Reset in the middle of a RUN burst: everything clears, no done pulse.
    cmd_valid = 1'b1; cmd_o_base = 10'h0F0; cmd_a_base = 10'h00F;
    cmd_o_stride = 10'h004; cmd_a_stride = 10'h008; cmd_rows = 5'd4; cmd_num_tiles = 8'd2;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk_int("mid_run_start", int'(gen_start), 1);
    #3 reset = 1'b1;
    #1 chk("reset_mid_run", z);
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_reset_idle", z);
    end
    run_cmd("after_reset", 10'h001, 10'h002, 10'h003, 10'h004, 5'd1, 8'd2, -1, 1'b0, ns, nb, lo, la);
    chk_int("after_reset_start_cycles", ns, 4);

    // Random commands against the schedule model.
    for (int r = 0; r < 40; r++) begin
      run_cmd("random", 10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom),
              5'($urandom_range(0, 6)), 8'($urandom_range(0, 4)),
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 50)) : -1,
              1'($urandom_range(0, 1)), ns, nb, lo, la);
      repeat ($urandom_range(0, 2)) begin
        step();
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || gen_start !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL idle_gap got rdy=%0b busy=%0b st=%0b dn=%0b expected 1 0 0 0",
                   cmd_ready, busy, gen_start, done);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
